// File: rtl/mem_align_unit.sv
// Byte-lane alignment and access splitting between the RV32I core memory port
// and word-organised physical memory; unaligned accesses become two transactions.
module mem_align_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_address,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_mbe,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [2:0] {IDLE, ACC1, GAP, ACC2, DONE} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [1:0]  size_q;
    logic        write_q;

    logic [31:0] src_addr;
    logic [31:0] src_wdata;
    logic [1:0]  src_size;
    logic [1:0]  off;
    logic [2:0]  nbytes;
    logic [2:0]  end_off;
    logic [3:0]  nmask;
    logic [31:0] byte_mask;
    logic [7:0]  mbe_wide;
    logic [63:0] wdata_wide;
    logic [63:0] rd_cat;
    logic [31:0] word_addr;
    logic [31:0] rd_aligned;
    logic        split;

    logic unused_funct3;
    assign unused_funct3 = core_funct3[2];

    // In IDLE the lane math runs on the live request so ACC1 outputs can be registered at acceptance.
    always_comb begin
        src_addr  = (state_q == IDLE) ? core_address     : addr_q;
        src_wdata = (state_q == IDLE) ? core_wdata       : wdata_q;
        src_size  = (state_q == IDLE) ? core_funct3[1:0] : size_q;
        case (src_size)
            2'b00: begin
                nbytes    = 3'd1;
                nmask     = 4'b0001;
                byte_mask = 32'h0000_00FF;
            end
            2'b01: begin
                nbytes    = 3'd2;
                nmask     = 4'b0011;
                byte_mask = 32'h0000_FFFF;
            end
            default: begin
                nbytes    = 3'd4;
                nmask     = 4'b1111;
                byte_mask = 32'hFFFF_FFFF;
            end
        endcase
        off        = src_addr[1:0];
        end_off    = {1'b0, off} + nbytes;
        split      = end_off > 3'd4;
        mbe_wide   = {4'b0000, nmask} << off;
        wdata_wide = {32'h0000_0000, src_wdata} << {off, 3'b000};
        word_addr  = {src_addr[31:2], 2'b00};
        // Upper halves of the widened vectors are the second-word lanes; hi is zero unless in ACC2.
        rd_cat     = (state_q == ACC2) ? {pmem_rdata, lo_q} : {32'h0000_0000, pmem_rdata};
        rd_aligned = 32'(rd_cat >> {off, 3'b000}) & byte_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
            core_rdata   <= '0;
            core_resp    <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_mbe     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_read || core_write) begin
                        addr_q       <= core_address;
                        wdata_q      <= core_wdata;
                        size_q       <= core_funct3[1:0];
                        write_q      <= core_write;
                        pmem_read    <= ~core_write;
                        pmem_write   <= core_write;
                        pmem_address <= word_addr;
                        pmem_mbe     <= mbe_wide[3:0];
                        pmem_wdata   <= wdata_wide[31:0];
                        state_q      <= ACC1;
                    end
                end
                ACC1: begin
                    if (pmem_resp) begin
                        lo_q       <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        if (split) begin
                            pmem_address <= word_addr + 32'd4;
                            pmem_mbe     <= mbe_wide[7:4];
                            pmem_wdata   <= wdata_wide[63:32];
                            state_q      <= GAP;
                        end else begin
                            core_resp <= 1'b1;
                            if (!write_q) core_rdata <= rd_aligned;
                            state_q   <= DONE;
                        end
                    end
                end
                GAP: begin
                    pmem_read  <= ~write_q;
                    pmem_write <= write_q;
                    state_q    <= ACC2;
                end
                ACC2: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        core_resp  <= 1'b1;
                        if (!write_q) core_rdata <= rd_aligned;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    core_resp <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Byte-lane alignment and access-splitting unit between the RV32I multicycle core's memory port (MAR, mem_data_out, MDR) and physical memory. It converts a byte-addressed load or store of 1, 2 or 4 bytes into one or two word-aligned memory transactions with byte enables. It returns load data right-justified in bits [7:0]/[15:0]/[31:0] so the core's regfilemux can extend it unchanged.

## Interface
- Parameters: none.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- core_read  in  1  load request; level, held until core_resp
- core_write  in  1  store request; level, held until core_resp
- core_funct3  in  3  load/store funct3; bits [1:0] select size: 00 byte, 01 half, 10 and 11 word
- core_address  in  32  byte address; stable while request held
- core_wdata  in  32  store data, right-justified
- core_rdata  out  32  load data, right-justified, zero above size
- core_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  word read strobe
- pmem_write  out  1  word write strobe
- pmem_address  out  32  word-aligned address, bits [1:0] always 00
- pmem_wdata  out  32  lane-positioned write data
- pmem_mbe  out  4  byte enables; bit i corresponds to byte lane [8i+7:8i]
- pmem_rdata  in  32  read data; valid when pmem_resp is high
- pmem_resp  in  1  one-cycle transaction-done pulse

## Operation
- FSM states: IDLE, ACC1, GAP, ACC2, DONE.
- **IDLE**
  - When core_read or core_write is high, latch address, size, wdata and op, then go to ACC1.
  - If both are high, perform the write and ignore the read.
- **Derived values**
  - n = 1, 2 or 4; o = address[1:0]; split when o + n > 4.
- **ACC1**
  - pmem_address = {address[31:2], 2'b00}; mbe = ((1<<n)-1) << o, truncated to 4 bits; pmem_wdata = wdata << 8·o.
  - On pmem_resp, capture pmem_rdata as lo, then go to GAP if split, otherwise to DONE.
- **GAP**
  - Strobes are low for exactly one cycle, then go to ACC2.
- **ACC2**
  - pmem_address = first word address + 4, wrapping modulo 2^32; mbe = (1<<(o+n-4))-1; pmem_wdata = wdata >> 8·(4-o).
  - On pmem_resp, capture pmem_rdata as hi, then go to DONE.
- **DONE**
  - core_resp = 1 for one cycle.
  - core_rdata = ({hi,lo} >> 8·o)[31:0], masked to n bytes; hi is treated as 0 when not split.
  - Return to IDLE.
- Strobes are decoded from state: pmem_read = (ACC1 or ACC2) and op is read; pmem_write likewise.
- Strobes stay high continuously until pmem_resp is sampled.
- pmem_mbe is also driven during reads; memory may ignore it.
- pmem_resp is ignored in IDLE, GAP and DONE.
- core_rdata holds its value until the next DONE; it is not updated for writes.
- No sign extension is performed here.

## Timing
- Reset values:
  - state IDLE.
  - core_resp, pmem_read and pmem_write are 0.
  - core_rdata, pmem_address, pmem_wdata and pmem_mbe are 0.
- Let T be the cycle a request is sampled in IDLE.
  - ACC1 strobe is high from T+1.
  - With zero-wait memory (pmem_resp in the first strobe cycle):
    - unsplit: core_resp at T+2.
    - split: GAP at T+2, ACC2 at T+3, core_resp at T+4.
  - Each memory wait cycle adds one cycle.
- The core must deassert its request in the cycle after core_resp.
  - The earliest next acceptance is the cycle after DONE, since IDLE samples then.
- rst in any state takes effect at the next edge:
  - state returns to IDLE and all outputs return to their reset values.
  - A pmem_resp arriving after reset is ignored.
  - No core_resp is produced for the aborted access.

## Test plan
- **Aligned lw at 0x100.** Memory returns 0xDEADBEEF after 2 wait cycles -> single access, pmem_address 0x100, mbe 1111, core_rdata 0xDEADBEEF, core_resp high for exactly 1 cycle at T+4.
- **lb/lbu at 0x103.** Memory word is 0x11223344 -> mbe 1000, core_rdata 0x00000011.
- **sh at 0x102, wdata 0x0000ABCD.** -> one write, pmem_address 0x100, mbe 1100, pmem_wdata 0xABCD0000.
- **Split lw at 0x0FE.** Memory holds 0x0FC=0xAABBCCDD and 0x100=0x11223344 -> reads 0x0FC with mbe 1100, one-cycle strobe gap, then 0x100 with mbe 0011; core_rdata 0x3344AABB.
- **Split sw at 0xFFFFFFFF, wdata 0x12345678, zero-wait memory.** -> first write 0xFFFFFFFC, mbe 1000, wdata 0x78000000; second write 0x00000000, mbe 0111, wdata 0x00123456; core_resp at T+4.
- **rst during ACC2 of a split read, then pmem_resp pulsed one cycle later.** -> strobes 0 the next cycle, state IDLE, no core_resp, core_rdata 0; a following aligned lw completes normally.
